// File: rtl/parking_gate_scheduler_pkg.sv
// Shared types and constants for the car park gate controller.
package parking_pkg;

  // 2-bit keypad password, shared with the single-lane parking FSM.
  typedef logic [1:0] pass_t;

  localparam pass_t PASS_CODE_DEF = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_OPEN_IN,
    ST_OPEN_OUT,
    ST_DENY
  } state_t;

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// Lane sensor / keypad / actuator bundle between the lanes and the scheduler.
interface parking_gate_scheduler_if
  import parking_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int CNT_W   = 7
);
  logic [N_LANES-1:0] entry_req;
  logic               exit_req;
  logic               pass_valid;
  pass_t              pass_code;
  logic [N_LANES-1:0] entry_grant;
  logic               gate_open;
  logic               green_led;
  logic               red_led;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;

  modport master (
    output entry_req, exit_req, pass_valid, pass_code,
    input  entry_grant, gate_open, green_led, red_led, count, full, empty
  );

  modport slave (
    input  entry_req, exit_req, pass_valid, pass_code,
    output entry_grant, gate_open, green_led, red_led, count, full, empty
  );
endinterface

// File: rtl/parking_gate_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);
  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // Scan lanes starting at the pointer, wrapping, and grant the first hit.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = PTR_W'((32'(i_ptr) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/parking_gate_scheduler.sv
// Shared-gate sequencer: entry arbitration, password check, gate windows, occupancy.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int    N_LANES        = 4,
  parameter int    CAPACITY       = 100,
  parameter int    CNT_W          = 7,
  parameter int    OPEN_CYCLES    = 16,
  parameter int    TIMEOUT_CYCLES = 64,
  parameter int    MAX_TRIES      = 3,
  parameter pass_t PASS_CODE      = PASS_CODE_DEF
) (
  input logic                     clk,
  input logic                     reset_n,
  parking_gate_scheduler_if.slave bus
);
  localparam int PTR_W   = $clog2(N_LANES);
  localparam int TMR_MAX = (TIMEOUT_CYCLES > OPEN_CYCLES) ? TIMEOUT_CYCLES : OPEN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int FAIL_W  = $clog2(MAX_TRIES + 1);

  state_t             r_state, w_state_n;
  logic [TMR_W-1:0]   r_timer, w_timer_n;
  logic [FAIL_W-1:0]  r_fail, w_fail_n;
  logic [PTR_W-1:0]   r_ptr, w_ptr_n;
  logic [N_LANES-1:0] r_grant, w_grant_n;
  logic               r_gate, w_gate_n;
  logic               r_green, w_green_n;
  logic               r_red, w_red_n;
  logic [CNT_W-1:0]   r_count, w_count_n;
  logic               r_full, r_empty;

  logic [N_LANES-1:0] w_arb_grant;
  logic [PTR_W-1:0]   w_lane;
  logic [PTR_W-1:0]   w_ptr_after;
  logic               w_open_last;

  rr_arbiter #(.N(N_LANES), .PTR_W(PTR_W)) u_arb (
    .i_req   (bus.entry_req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant)
  );

  // Index of the currently granted lane; the pointer resumes just past it.
  always_comb begin
    w_lane = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (r_grant[i]) w_lane = PTR_W'(i);
    end
    w_ptr_after = (w_lane == PTR_W'(N_LANES - 1)) ? '0 : w_lane + 1'b1;
    w_open_last = (r_timer == TMR_W'(OPEN_CYCLES - 1));
  end

  // Next-state and next-output logic; one timer serves CHECK timeout and all windows.
  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer;
    w_fail_n  = r_fail;
    w_ptr_n   = r_ptr;
    w_grant_n = r_grant;
    w_gate_n  = 1'b0;
    w_green_n = 1'b0;
    w_red_n   = 1'b0;
    w_count_n = r_count;
    unique case (r_state)
      ST_IDLE: begin
        w_grant_n = '0;
        if (bus.exit_req && !r_empty) begin
          w_state_n = ST_OPEN_OUT;
          w_timer_n = '0;
          w_gate_n  = 1'b1;
        end else if ((|bus.entry_req) && !r_full) begin
          w_state_n = ST_CHECK;
          w_grant_n = w_arb_grant;
          w_fail_n  = '0;
          w_timer_n = '0;
        end
      end
      ST_CHECK: begin
        w_timer_n = r_timer + 1'b1;
        if (!(|(bus.entry_req & r_grant))) begin
          w_state_n = ST_IDLE;
          w_grant_n = '0;
          w_ptr_n   = w_ptr_after;
        end else if (bus.pass_valid && bus.pass_code == PASS_CODE) begin
          w_state_n = ST_OPEN_IN;
          w_grant_n = '0;
          w_ptr_n   = w_ptr_after;
          w_timer_n = '0;
          w_gate_n  = 1'b1;
          w_green_n = 1'b1;
        end else if (bus.pass_valid) begin
          w_red_n   = 1'b1;
          w_timer_n = '0;
          w_fail_n  = r_fail + 1'b1;
          // The last allowed miss flows straight into the deny window.
          if (r_fail == FAIL_W'(MAX_TRIES - 1)) begin
            w_state_n = ST_DENY;
            w_grant_n = '0;
            w_ptr_n   = w_ptr_after;
          end
        end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_n = ST_IDLE;
          w_grant_n = '0;
          w_ptr_n   = w_ptr_after;
        end
      end
      ST_OPEN_IN: begin
        if (w_open_last) begin
          w_state_n = ST_IDLE;
          w_timer_n = '0;
          w_count_n = r_count + 1'b1;
        end else begin
          w_timer_n = r_timer + 1'b1;
          w_gate_n  = 1'b1;
          w_green_n = 1'b1;
        end
      end
      ST_OPEN_OUT: begin
        if (w_open_last) begin
          w_state_n = ST_IDLE;
          w_timer_n = '0;
          w_count_n = r_count - 1'b1;
        end else begin
          w_timer_n = r_timer + 1'b1;
          w_gate_n  = 1'b1;
        end
      end
      ST_DENY: begin
        if (w_open_last) begin
          w_state_n = ST_IDLE;
          w_timer_n = '0;
        end else begin
          w_timer_n = r_timer + 1'b1;
          w_red_n   = 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs; full/empty track the next count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_fail  <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_gate  <= 1'b0;
      r_green <= 1'b0;
      r_red   <= 1'b0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_fail  <= w_fail_n;
      r_ptr   <= w_ptr_n;
      r_grant <= w_grant_n;
      r_gate  <= w_gate_n;
      r_green <= w_green_n;
      r_red   <= w_red_n;
      r_count <= w_count_n;
      r_full  <= (w_count_n == CNT_W'(CAPACITY));
      r_empty <= (w_count_n == '0);
    end
  end

  assign bus.entry_grant = r_grant;
  assign bus.gate_open   = r_gate;
  assign bus.green_led   = r_green;
  assign bus.red_led     = r_red;
  assign bus.count       = r_count;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Randomized self-checking bench for parking_gate_scheduler with a transaction-level model.
module tb_parking_gate_scheduler;
  localparam int N     = 4;
  localparam int CAP   = 8;
  localparam int CW    = 4;
  localparam int OPEN  = 16;
  localparam int TMO   = 64;
  localparam int TRIES = 3;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   m_count;
  int   m_ptr;

  parking_gate_scheduler_if #(.N_LANES(N), .CNT_W(CW)) bus ();

  parking_gate_scheduler #(
    .N_LANES        (N),
    .CAPACITY       (CAP),
    .CNT_W          (CW),
    .OPEN_CYCLES    (OPEN),
    .TIMEOUT_CYCLES (TMO),
    .MAX_TRIES      (TRIES),
    .PASS_CODE      (2'b11)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requesting lane at or after the pointer.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic do_entry(input logic [N-1:0] req, input int n_wrong, input bit good);
    int lane;
    logic [1:0] bad;
    lane = pick(req, m_ptr);
    bus.entry_req = req;
    tick();
    check("grant", bus.entry_grant, 32'(1) << lane);
    for (int w = 0; w < n_wrong; w++) begin
      bad = 2'($urandom_range(0, 2));
      bus.pass_valid = 1'b1;
      bus.pass_code  = bad;
      tick();
      bus.pass_valid = 1'b0;
      check("red_wrong", bus.red_led, 1);
      check("gate_wrong", bus.gate_open, 0);
      if (w == TRIES - 1) begin
        check("grant_deny", bus.entry_grant, 0);
        for (int i = 0; i < OPEN; i++) begin
          check("red_deny", bus.red_led, 1);
          check("gate_deny", bus.gate_open, 0);
          tick();
        end
        check("red_deny_end", bus.red_led, 0);
        check("count_deny", bus.count, m_count);
        m_ptr = (lane + 1) % N;
        return;
      end
      tick();
      check("red_pulse_end", bus.red_led, 0);
      check("grant_held", bus.entry_grant, 32'(1) << lane);
    end
    if (good) begin
      bus.pass_valid = 1'b1;
      bus.pass_code  = 2'b11;
      tick();
      bus.pass_valid = 1'b0;
      for (int i = 0; i < OPEN; i++) begin
        check("gate_in", bus.gate_open, 1);
        check("green_in", bus.green_led, 1);
        check("count_hold", bus.count, m_count);
        tick();
      end
      m_count++;
      check("gate_in_end", bus.gate_open, 0);
      check("green_end", bus.green_led, 0);
      check("count_inc", bus.count, m_count);
      check("full_inc", bus.full, (m_count == CAP) ? 1 : 0);
      check("empty_inc", bus.empty, 0);
    end else begin
      bus.entry_req = '0;
      tick();
      check("grant_drop", bus.entry_grant, 0);
      check("count_drop", bus.count, m_count);
    end
    m_ptr = (lane + 1) % N;
  endtask

  task automatic do_exit();
    bus.exit_req = 1'b1;
    tick();
    bus.exit_req = 1'b0;
    for (int i = 0; i < OPEN; i++) begin
      check("gate_out", bus.gate_open, 1);
      check("green_out", bus.green_led, 0);
      tick();
    end
    m_count--;
    check("gate_out_end", bus.gate_open, 0);
    check("count_dec", bus.count, m_count);
    check("full_dec", bus.full, 0);
    check("empty_dec", bus.empty, (m_count == 0) ? 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lane;
    logic [N-1:0] rq;
    int nw;
    bit gd;
    checks = 0;
    failures = 0;
    m_count = 0;
    m_ptr = 0;
    reset_n = 1'b0;
    bus.entry_req = '0;
    bus.exit_req = 1'b0;
    bus.pass_valid = 1'b0;
    bus.pass_code = 2'b00;
    repeat (2) tick();
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_grant", bus.entry_grant, 0);
    check("rst_gate", bus.gate_open, 0);
    check("rst_leds", {bus.green_led, bus.red_led}, 0);
    reset_n = 1'b1;
    tick();

    // Stray keypad strobe and exit while empty are both ignored.
    bus.pass_valid = 1'b1;
    bus.pass_code = 2'b11;
    bus.exit_req = 1'b1;
    repeat (3) begin
      tick();
      check("idle_ignore_gate", bus.gate_open, 0);
      check("idle_ignore_grant", bus.entry_grant, 0);
    end
    bus.pass_valid = 1'b0;
    bus.exit_req = 1'b0;
    tick();

    // Fairness: lanes 0,1,3 held.
    repeat (4) do_entry(4'b1011, 0, 1'b1);
    // Single lane 2.
    do_entry(4'b0100, 0, 1'b1);
    // Three wrong codes on lane 0, then lane 1 is next.
    do_entry(4'b0001, TRIES, 1'b0);
    do_entry(4'b1111, 0, 1'b1);

    // Timeout: no keypad activity for the whole window.
    bus.entry_req = '1;
    lane = pick(4'b1111, m_ptr);
    tick();
    check("grant_to", bus.entry_grant, 32'(1) << lane);
    repeat (TMO - 1) begin
      tick();
      check("grant_wait", bus.entry_grant, 32'(1) << lane);
    end
    tick();
    check("grant_timeout", bus.entry_grant, 0);
    check("count_timeout", bus.count, m_count);
    m_ptr = (lane + 1) % N;
    do_entry(4'b1111, 1, 1'b0);

    // Capacity: fill, hold off, exit makes room.
    while (m_count < CAP) do_entry(4'b1111, 0, 1'b1);
    bus.entry_req = '1;
    repeat (5) begin
      tick();
      check("full_flag", bus.full, 1);
      check("full_no_grant", bus.entry_grant, 0);
    end
    do_exit();
    do_entry(4'b1111, 0, 1'b1);
    bus.entry_req = '0;
    do_exit();

    // Asynchronous reset in the middle of an entry window.
    bus.entry_req = 4'b0001;
    lane = pick(4'b0001, m_ptr);
    tick();
    check("grant_rst", bus.entry_grant, 32'(1) << lane);
    bus.pass_valid = 1'b1;
    bus.pass_code = 2'b11;
    tick();
    bus.pass_valid = 1'b0;
    bus.entry_req = '0;
    repeat (3) tick();
    check("gate_before_rst", bus.gate_open, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_gate", bus.gate_open, 0);
    check("rst_async_count", bus.count, 0);
    check("rst_async_empty", bus.empty, 1);
    #10 reset_n = 1'b1;
    m_count = 0;
    m_ptr = 0;
    tick();
    check("post_rst_gate", bus.gate_open, 0);

    // Simultaneous exit and entry with one car inside: exit wins.
    do_entry(4'b0010, 0, 1'b1);
    bus.entry_req = 4'b0100;
    do_exit();
    do_entry(4'b0100, 0, 1'b1);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      if (m_count > 0 && (m_count == CAP || $urandom_range(0, 3) == 0)) begin
        bus.entry_req = '0;
        do_exit();
      end else begin
        rq = N'($urandom_range(1, (1 << N) - 1));
        nw = $urandom_range(0, TRIES);
        gd = (nw < TRIES) && ($urandom_range(0, 3) != 0);
        do_entry(rq, nw, gd);
      end
    end
    bus.entry_req = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parking_gate_scheduler.md
# parking_gate_scheduler

Sequencing controller for a car park with several entrance lanes and one exit lane sharing a single barrier gate and occupancy counter. It arbitrates entrance lanes round-robin, gives exits priority, and runs the 2-bit password check for the granted lane. It opens the gate for a fixed window and updates occupancy. It sits between the lane sensors/keypads and the gate actuator and LED drivers.

## Interface
- N_LANES, 4, number of entrance lanes (2..8)
- CAPACITY, 100, maximum parked cars
- CNT_W, 7, occupancy counter width; must hold CAPACITY
- OPEN_CYCLES, 16, gate-open / deny-indication window in clk cycles
- TIMEOUT_CYCLES, 64, max wait for a password in CHECK
- MAX_TRIES, 3, wrong passwords before a lane is denied
- PASS_CODE, 2'b11, accepted password

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- entry_req  in  N_LANES  per-lane car-present sensor (level)
- exit_req  in  1  exit sensor (level)
- pass_valid  in  1  one-cycle strobe: pass_code valid for the granted lane
- pass_code  in  2  password from the shared keypad mux
- entry_grant  out  N_LANES  one-hot grant; selects keypad mux
- gate_open  out  1  barrier open
- green_led  out  1  entry accepted
- red_led  out  1  wrong password or lane denied
- count  out  CNT_W  current occupancy
- full  out  1  count == CAPACITY
- empty  out  1  count == 0

## Operation
- States: IDLE, CHECK, OPEN_IN, OPEN_OUT, DENY. All outputs registered.
- IDLE:
  - If exit_req and !empty: go to OPEN_OUT. Exit beats entry in the same cycle.
  - Else if any entry_req and !full: grant the first requesting lane at or after rr_ptr (wrapping), clear fail_cnt and timer, go to CHECK.
  - exit_req while empty is ignored. entry_req while full is held off; no grant is issued.
- CHECK: entry_grant held.
  - pass_valid with pass_code == PASS_CODE: go to OPEN_IN.
  - pass_valid with a wrong code: red_led for 1 cycle, fail_cnt++, timer restarts. When fail_cnt reaches MAX_TRIES, go to DENY.
  - Timer reaches TIMEOUT_CYCLES, or the granted lane drops entry_req: go to IDLE with no count change.
- OPEN_IN: gate_open=1, green_led=1 for OPEN_CYCLES cycles. On the last cycle, count++ and return to IDLE.
- OPEN_OUT: gate_open=1 for OPEN_CYCLES cycles. On the last cycle, count-- and return to IDLE.
- DENY: red_led=1 for OPEN_CYCLES cycles, gate stays closed, then IDLE.
- rr_ptr moves to granted lane+1 (mod N_LANES) whenever CHECK is left by any path. Every requesting lane is served within N_LANES entry grants.
- count never exceeds CAPACITY and never underflows; no wrap-around is possible by construction.
- Exit requests during CHECK/OPEN_IN/DENY wait for IDLE. Entry requests during OPEN_OUT wait likewise.

## Timing
- Reset values: state IDLE, count 0, empty 1, full 0, entry_grant 0, gate_open 0, LEDs 0, rr_ptr 0, fail_cnt 0.
- Reset is asynchronous mid-operation: gate closes immediately and occupancy is lost.
- Request to grant/gate: entry_req high at edge k gives entry_grant at k+1. exit_req gives gate_open at k+1.
- Correct pass_valid at edge k: gate_open and green_led from k+1 through k+OPEN_CYCLES. count updates at k+OPEN_CYCLES+1, the same edge state returns to IDLE.
- full/empty are derived registered from the next count and are coincident with count.
- pass_valid outside CHECK is ignored.
- Back-to-back service: a new grant can occur on the cycle after returning to IDLE.

## Structure
- Package parking_pkg holds:
  - the state enum
  - PASS_CODE default
  - the shared 2-bit password type, also usable by the existing single-lane parking FSM
- Sub-module rr_arbiter (N parameter): req vector and ptr in, one-hot grant out, combinational. It is instantiated once.
- Timer is a single counter shared by the CHECK timeout and the OPEN/DENY windows.

## Test plan
- Single lane: lane 2 requests, pass_valid with 2'b11 → grant 0100 next cycle, gate_open for 16 cycles, count 0→1.
- Fairness: lanes 0,1,3 held high, all correct passwords → grants in order 0001, 0010, 1000, 0001; count increments each time.
- Wrong passwords: lane 0 sends 2'b01 three times → three 1-cycle red pulses, then red_led held 16 cycles, gate never opens, count unchanged, next grant goes to lane 1.
- Capacity: CAPACITY=2, fill to 2 → full=1 and lane requests get no grant. exit_req → gate opens, count 2→1, full=0, next entry granted.
- Simultaneous: exit_req and entry_req rise in the same cycle with count=1 → OPEN_OUT first, count→0, then entry grant.
- Timeout and reset: granted lane sends no pass_valid for 64 cycles → back to IDLE, ptr advances. Assert reset_n low during OPEN_IN → gate_open drops asynchronously, count=0.
